// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one decoded FP op to FPU_Top, captures its result and sticky fflags, returns it via valid/ready
module fpu_issue_ctrl #(
  parameter int TAG_W    = 5,
  parameter bit RM_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_sfpu_op,
  input  logic [2:0]       req_frm,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [31:0]      req_rs3,
  input  logic [31:0]      req_int,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  output logic [31:0]      fpu_op_c,
  output logic [31:0]      fpu_int,
  output logic [23:0]      fpu_sfpu_op,
  output logic [2:0]       fpu_frm,
  input  logic [31:0]      fpu_result,
  input  logic [31:0]      fpu_result_rd,
  input  logic [4:0]       fpu_flags,
  input  logic             fpu_exc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_to_int,
  output logic             rsp_exc,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             csr_frm_we,
  input  logic [2:0]       csr_frm_wdata,
  input  logic             csr_ff_we,
  input  logic [4:0]       csr_ff_wdata,
  output logic [2:0]       fcsr_frm,
  output logic [4:0]       fcsr_fflags
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  localparam logic [21:0] RND_MASK = 22'h03F01F;
  localparam logic [21:0] INT_MASK = 22'h204E80;
  state_t state;
  logic [2:0] rm;
  logic illegal;
  // resolve dynamic rounding against the current (pre-write) fcsr.frm and classify the request
  always_comb begin
    rm = req_frm == 3'b111 ? fcsr_frm : req_frm;
    illegal = !$onehot(req_sfpu_op[21:0]) ||
              (RM_CHECK && (rm == 3'b101 || rm == 3'b110) && |(req_sfpu_op[21:0] & RND_MASK));
  end
  // issue/capture/response sequencer with fcsr state; rsp_to_int is decided at accept and steers the capture mux
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      fpu_op_c    <= '0;
      fpu_int     <= '0;
      fpu_sfpu_op <= '0;
      fpu_frm     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_to_int  <= 1'b0;
      rsp_exc     <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
      fcsr_frm    <= '0;
      fcsr_fflags <= '0;
    end else begin
      fcsr_frm    <= csr_frm_we ? csr_frm_wdata : fcsr_frm;
      fcsr_fflags <= (csr_ff_we ? csr_ff_wdata : fcsr_fflags) | (state == CAPTURE ? fpu_flags : 5'd0);
      unique case (state)
        IDLE: if (req_valid) begin
          req_ready   <= 1'b0;
          fpu_op_a    <= req_rs1;
          fpu_op_b    <= req_rs2;
          fpu_op_c    <= req_rs3;
          fpu_int     <= req_int;
          fpu_frm     <= rm;
          fpu_sfpu_op <= illegal ? 24'd0 : req_sfpu_op;
          rsp_tag     <= req_tag;
          rsp_exc     <= 1'b0;
          rsp_illegal <= illegal;
          rsp_to_int  <= !illegal && |(req_sfpu_op[21:0] & INT_MASK);
          rsp_data    <= '0;
          rsp_valid   <= illegal;
          state       <= illegal ? RESP : ISSUE;
        end
        ISSUE: begin
          rsp_exc     <= fpu_exc;
          fpu_sfpu_op <= '0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data  <= rsp_to_int ? fpu_result_rd : fpu_result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench with a registered FPU stub behind the controller
module tb_fpu_issue_ctrl;
  localparam logic [21:0] RND = 22'h03F01F;
  localparam logic [21:0] TOI = 22'h204E80;
  typedef struct {
    logic [31:0] data;
    logic        to_int;
    logic        exc;
    logic        illegal;
    logic [4:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb[$];
  logic clk = 0, rst_l = 0;
  logic req_valid = 0, req_ready;
  logic [23:0] req_sfpu_op = 0;
  logic [2:0] req_frm = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0, req_rs3 = 0, req_int = 0;
  logic [4:0] req_tag = 0;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_op_c, fpu_int;
  logic [23:0] fpu_sfpu_op;
  logic [2:0] fpu_frm;
  logic [31:0] fpu_result = 0, fpu_result_rd = 0;
  logic [4:0] fpu_flags = 0;
  logic fpu_exc;
  logic rsp_valid, rsp_ready = 1, rsp_to_int, rsp_exc, rsp_illegal;
  logic [31:0] rsp_data;
  logic [4:0] rsp_tag;
  logic csr_frm_we = 0, csr_ff_we = 0;
  logic [2:0] csr_frm_wdata = 0, fcsr_frm;
  logic [4:0] csr_ff_wdata = 0, fcsr_fflags;
  logic [31:0] stub_res = 0, stub_rd = 0;
  logic [4:0] stub_fl = 0;
  logic stub_exc = 0;
  logic [2:0] model_frm = 0;
  logic [4:0] model_ff = 0;
  int total = 0, passed = 0, issue_cnt = 0;

  fpu_issue_ctrl #(.TAG_W(5), .RM_CHECK(1'b1)) dut (
    .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_ready(req_ready),
    .req_sfpu_op(req_sfpu_op), .req_frm(req_frm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs3(req_rs3), .req_int(req_int), .req_tag(req_tag),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_op_c(fpu_op_c), .fpu_int(fpu_int),
    .fpu_sfpu_op(fpu_sfpu_op), .fpu_frm(fpu_frm), .fpu_result(fpu_result),
    .fpu_result_rd(fpu_result_rd), .fpu_flags(fpu_flags), .fpu_exc(fpu_exc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_to_int(rsp_to_int),
    .rsp_exc(rsp_exc), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .csr_frm_we(csr_frm_we), .csr_frm_wdata(csr_frm_wdata), .csr_ff_we(csr_ff_we),
    .csr_ff_wdata(csr_ff_wdata), .fcsr_frm(fcsr_frm), .fcsr_fflags(fcsr_fflags)
  );

  always #5 clk = ~clk;

  // FPU stub: result and flags are only meaningful the cycle after an issued opcode
  assign fpu_exc = (fpu_sfpu_op != 0) && stub_exc;
  always @(posedge clk) begin
    fpu_result    <= fpu_sfpu_op != 0 ? stub_res : 32'hDEADBEEF;
    fpu_result_rd <= fpu_sfpu_op != 0 ? stub_rd : 32'hDEADBEEF;
    fpu_flags     <= fpu_sfpu_op != 0 ? stub_fl : 5'd0;
    if (fpu_sfpu_op != 0) issue_cnt <= issue_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic send(input logic [23:0] op, input logic [2:0] frm, input logic [31:0] a, b,
                      input logic [4:0] tag, input logic [31:0] sres, srd, input logic [4:0] sfl,
                      input logic sexc, input logic frm_we, input logic [2:0] frm_wd, input bit hold);
    exp_t e, g;
    logic [2:0] rm;
    logic ill;
    int cyc, issues0;
    logic [31:0] held;
    rm = frm == 3'b111 ? model_frm : frm;
    ill = $countones(op[21:0]) != 1 || ((rm == 3'b101 || rm == 3'b110) && |(op[21:0] & RND));
    e.illegal = ill;
    e.to_int = !ill && |(op[21:0] & TOI);
    e.data = ill ? 32'd0 : (e.to_int ? srd : sres);
    e.exc = !ill && sexc;
    e.tag = tag;
    e.lat = ill ? 1 : 3;
    sb.push_back(e);
    if (!ill) model_ff = model_ff | sfl;
    if (frm_we) model_frm = frm_wd;
    issues0 = issue_cnt;
    stub_res = sres; stub_rd = srd; stub_fl = sfl; stub_exc = sexc;
    rsp_ready = !hold;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_sfpu_op = op; req_frm = frm; req_rs1 = a; req_rs2 = b;
    req_rs3 = 32'h1234_5678; req_int = 32'h0000_0007; req_tag = tag;
    csr_frm_we = frm_we; csr_frm_wdata = frm_wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; csr_frm_we = 0;
    cyc = 1;
    check("issue_opcode", {8'd0, fpu_sfpu_op}, ill ? 32'd0 : {8'd0, op});
    if (!ill) begin
      check("issue_frm", {29'd0, fpu_frm}, {29'd0, rm});
      check("issue_op_a", fpu_op_a, a);
    end
    while (!rsp_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc < 3) check("opcode_cleared", {8'd0, fpu_sfpu_op}, 32'd0);
    end
    g = sb.pop_front();
    check("latency", cyc, g.lat);
    check("rsp_data", rsp_data, g.data);
    check("rsp_to_int", {31'd0, rsp_to_int}, {31'd0, g.to_int});
    check("rsp_exc", {31'd0, rsp_exc}, {31'd0, g.exc});
    check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, g.illegal});
    check("rsp_tag", {27'd0, rsp_tag}, {27'd0, g.tag});
    check("fflags", {27'd0, fcsr_fflags}, {27'd0, model_ff});
    if (ill) check("no_issue", issue_cnt, issues0);
    if (hold) begin
      held = rsp_data;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_data", rsp_data, held);
        check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1;
    end
    @(negedge clk);
    check("back_idle_ready", {31'd0, req_ready}, 32'd1);
    check("back_idle_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic saw;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_fflags", {27'd0, fcsr_fflags}, 32'd0);
    rst_l = 1;
    @(negedge clk);
    send(24'h000001, 3'b000, 32'h3F800000, 32'h40000000, 5'd1, 32'h40400000, 32'hDEAD0001, 5'b00000, 1'b0, 1'b0, 3'd0, 0);
    send(24'h000008, 3'b000, 32'h3F800000, 32'h00000000, 5'd2, 32'h7F800000, 32'hDEAD0002, 5'b01000, 1'b1, 1'b0, 3'd0, 0);
    send(24'h000001, 3'b000, 32'h3F800000, 32'h3F800000, 5'd3, 32'h40000000, 32'hDEAD0003, 5'b00000, 1'b0, 1'b0, 3'd0, 0);
    send(24'h804000, 3'b111, 32'h3FC00000, 32'h0, 5'd4, 32'h0BAD0BAD, 32'h00000002, 5'b00001, 1'b0, 1'b1, 3'b010, 0);
    check("fcsr_frm_written", {29'd0, fcsr_frm}, 32'd2);
    send(24'h000003, 3'b000, 32'h1, 32'h2, 5'd5, 32'h11111111, 32'h22222222, 5'b10000, 1'b0, 1'b0, 3'd0, 0);
    send(24'h000001, 3'b101, 32'h1, 32'h2, 5'd6, 32'h11111111, 32'h22222222, 5'b10000, 1'b0, 1'b0, 3'd0, 0);
    send(24'h000080, 3'b101, 32'h1, 32'h2, 5'd7, 32'h33333333, 32'h00000055, 5'b00000, 1'b0, 1'b0, 3'd0, 0);
    @(negedge clk);
    csr_ff_we = 1; csr_ff_wdata = 5'd0;
    @(negedge clk);
    csr_ff_we = 0; model_ff = 0;
    check("fflags_cleared", {27'd0, fcsr_fflags}, 32'd0);
    send(24'h000002, 3'b001, 32'h40000000, 32'h3F800000, 5'd8, 32'h3F800000, 32'hDEAD0008, 5'b00100, 1'b0, 1'b0, 3'd0, 1);
    stub_fl = 5'b00010; stub_res = 32'h40800000;
    req_valid = 1; req_sfpu_op = 24'h000001; req_frm = 3'b000; req_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_l = 0;
    #1;
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    check("arst_opcode", {8'd0, fpu_sfpu_op}, 32'd0);
    check("arst_op_a", fpu_op_a, 32'd0);
    check("arst_fcsr", {24'd0, fcsr_frm, fcsr_fflags}, 32'd0);
    model_ff = 0; model_frm = 0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1;
    saw = 0;
    for (cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      saw = saw | rsp_valid;
    end
    check("no_rsp_after_reset", {31'd0, saw}, 32'd0);
    check("fflags_after_reset", {27'd0, fcsr_fflags}, 32'd0);
    send(24'h000001, 3'b111, 32'h3F800000, 32'h40000000, 5'd10, 32'h40400000, 32'hDEAD000A, 5'b00000, 1'b0, 1'b0, 3'd0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
